// File: rtl/jk_pkg.sv
// jk_pkg: shared types and constants for the JK bank drive controller.
//   state_e            - controller FSM states
//   JK_HOLD/CLR/SET/TGL - {j,k} excitation codes understood by the driven bank
package jk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_e;

    // Codes are {j,k}: 10 clears the flop, 01 sets it.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b10;
    localparam logic [1:0] JK_SET  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_drive_ctrl_if.sv
// jk_drive_ctrl_if: target request handshake into the JK drive controller.
//   tgt_valid - request present (master -> slave)
//   tgt_data  - desired bank state (master -> slave)
//   tgt_ready - controller can accept (slave -> master)
interface jk_drive_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (output tgt_valid, output tgt_data, input tgt_ready);
    modport slave  (input tgt_valid, input tgt_data, output tgt_ready);

endinterface

// File: rtl/jk_excite.sv
// jk_excite: combinational per-bit excitation from current Q and target.
//   q - present bank state, t - target state, j/k - per-bit drive codes.
// Build option JK_DRIVE_TOGGLE_EN: differing bits are driven with toggle (11)
// instead of a directed set/clear; matching bits always hold (00).
module jk_excite
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (q[i] != t[i]) begin
`ifdef JK_DRIVE_TOGGLE_EN
                {j[i], k[i]} = JK_TGL;
`else
                {j[i], k[i]} = q[i] ? JK_CLR : JK_SET;
`endif
            end else begin
                {j[i], k[i]} = JK_HOLD;
            end
        end
    end

endmodule

// File: rtl/jk_drive_ctrl.sv
// jk_drive_ctrl: drives a bank of JK flops to a requested state and verifies it.
//   clk, rst      - clock shared with the bank; async active-high reset
//   tgt (slave)   - tgt_valid/tgt_ready/tgt_data request handshake
//   q_fb          - Q outputs fed back from the bank
//   j, k          - registered per-bit drive, non-zero only for one DRIVE cycle
//   busy          - operation in progress (DRIVE/SETTLE/CHECK)
//   done, err     - one-cycle result pulses (match / retries exhausted)
// Build option JK_DRIVE_TOGGLE_EN selects toggle excitation in jk_excite.
module jk_drive_ctrl
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             rst,
    jk_drive_ctrl_if.slave   tgt,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   ex_tgt, ex_j, ex_k;
    logic               xfer;

    // Ready is masked by rst so it reads 0 for the whole reset assertion.
    assign tgt.tgt_ready = (state_q == ST_IDLE) && !rst;
    assign xfer          = tgt.tgt_valid && tgt.tgt_ready;

    // On the transfer edge the target register is not yet loaded; use the bus.
    assign ex_tgt = (state_q == ST_IDLE) ? tgt.tgt_data : tgt_q;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q (q_fb),
        .t (ex_tgt),
        .j (ex_j),
        .k (ex_k)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rty_d   = rty_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    tgt_d   = tgt.tgt_data;
                    rty_d   = '0;
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rty_q < RTY_W'(MAX_RETRY)) begin
                    // Re-drive from the bank's present state, not the original one.
                    rty_d   = rty_q + RTY_W'(1);
                    j_d     = ex_j;
                    k_d     = ex_k;
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign j    = j_q;
    assign k    = k_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// tb_jk_drive_ctrl: directed self-checking bench for jk_drive_ctrl with a
// behavioural JK bank (reset value all-ones, optional stuck-at-0 bits).
// Expectations follow JK_DRIVE_TOGGLE_EN when the build defines it.
module tb_jk_drive_ctrl;

`ifdef JK_DRIVE_TOGGLE_EN
    localparam bit TGL = 1'b1;
`else
    localparam bit TGL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bank_rst = 1'b0;
    logic [7:0] q_fb;
    logic [7:0] j, k;
    logic       busy, done, err;
    logic [7:0] bank_q;
    logic [7:0] stuck0 = 8'h00;

    int errors = 0;
    int checks = 0;
    int drive_cnt;

    jk_drive_ctrl_if #(.WIDTH(8)) tgt_if ();

    jk_drive_ctrl #(.WIDTH(8), .SETTLE_CYC(1), .MAX_RETRY(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .tgt  (tgt_if),
        .q_fb (q_fb),
        .j    (j),
        .k    (k),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank: 00 hold, 10 clear, 01 set, 11 toggle.
    always_ff @(posedge clk or posedge bank_rst) begin
        if (bank_rst) begin
            bank_q <= 8'hFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                case ({j[i], k[i]})
                    2'b00: bank_q[i] <= bank_q[i] & ~stuck0[i];
                    2'b10: bank_q[i] <= 1'b0;
                    2'b01: bank_q[i] <= ~stuck0[i];
                    default: bank_q[i] <= ~bank_q[i] & ~stuck0[i];
                endcase
            end
        end
    end
    assign q_fb = bank_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pick(input logic [7:0] directed, input logic [7:0] toggle);
        return TGL ? toggle : directed;
    endfunction

    // One transfer against a cooperative bank: DRIVE, SETTLE, CHECK, done.
    task automatic run_xfer(input string tag, input logic [7:0] t,
                            input logic [7:0] ej, input logic [7:0] ek);
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = t;
        check({tag, "_ready_idle"}, 32'(tgt_if.tgt_ready), 32'd1);
        tick();
        tgt_if.tgt_valid = 1'b0;
        check({tag, "_drive_j"}, 32'(j), 32'(ej));
        check({tag, "_drive_k"}, 32'(k), 32'(ek));
        check({tag, "_drive_busy"}, 32'(busy), 32'd1);
        check({tag, "_drive_ready"}, 32'(tgt_if.tgt_ready), 32'd0);
        tick();
        check({tag, "_settle_jk"}, 32'({j, k}), 32'd0);
        check({tag, "_settle_done"}, 32'(done), 32'd0);
        tick();
        check({tag, "_check_busy"}, 32'(busy), 32'd1);
        check({tag, "_check_done"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_q"}, 32'(q_fb), 32'(t));
    endtask

    // done and err must never coincide.
    always @(negedge clk) begin
        if (!rst) check("done_err_excl", 32'(done & err), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tgt_if.tgt_valid = 1'b0;
        tgt_if.tgt_data  = 8'h00;

        // Reset
        #2;
        rst = 1'b1;
        bank_rst = 1'b1;
        #1;
        check("rst_ready", 32'(tgt_if.tgt_ready), 32'd0);
        check("rst_outs", 32'({j, k, busy, done, err}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        bank_rst = 1'b0;
        #1;
        check("rel_ready", 32'(tgt_if.tgt_ready), 32'd1);
        check("rel_q", 32'(q_fb), 32'hFF);
        tick();

        // FF -> 0F
        run_xfer("t0F", 8'h0F, 8'hF0, pick(8'h00, 8'hF0));
        tick();
        check("t0F_done_clr", 32'(done), 32'd0);

        // Target equal to bank: all hold
        run_xfer("same", 8'h0F, 8'h00, 8'h00);

        // 0F -> 00, then bit0 stuck at 0 and request 01
        run_xfer("t00", 8'h00, 8'h0F, pick(8'h00, 8'h0F));
        stuck0 = 8'h01;
        drive_cnt = 0;
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'h01;
        tick();
        tgt_if.tgt_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if ((j | k) != 8'h00) drive_cnt++;
            if (i % 3 == 0) begin
                check("stuck_drive_j", 32'(j), 32'(pick(8'h00, 8'h01)));
                check("stuck_drive_k", 32'(k), 32'h01);
            end else begin
                check("stuck_idle_jk", 32'({j, k}), 32'd0);
            end
            check("stuck_done", 32'(done), 32'd0);
            check("stuck_err_early", 32'(err), 32'd0);
            check("stuck_busy", 32'(busy), 32'd1);
            tick();
        end
        check("stuck_err", 32'(err), 32'd1);
        check("stuck_no_done", 32'(done), 32'd0);
        check("stuck_drive_cnt", 32'(drive_cnt), 32'd3);
        check("stuck_q", 32'(q_fb), 32'h00);
        tick();
        check("stuck_err_pulse", 32'(err), 32'd0);
        stuck0 = 8'h00;

        // Held valid: AA then 55, second transfer in the done cycle
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'hAA;
        tick();
        check("bb_aa_j", 32'(j), 32'(pick(8'h00, 8'hAA)));
        check("bb_aa_k", 32'(k), 32'hAA);
        tgt_if.tgt_data = 8'h55;
        check("bb_ready0", 32'(tgt_if.tgt_ready), 32'd0);
        tick();
        check("bb_ready1", 32'(tgt_if.tgt_ready), 32'd0);
        tick();
        check("bb_ready2", 32'(tgt_if.tgt_ready), 32'd0);
        tick();
        check("bb_aa_done", 32'(done), 32'd1);
        check("bb_aa_q", 32'(q_fb), 32'hAA);
        check("bb_ready_done", 32'(tgt_if.tgt_ready), 32'd1);
        tick();
        tgt_if.tgt_valid = 1'b0;
        check("bb_55_j", 32'(j), 32'(pick(8'hAA, 8'hFF)));
        check("bb_55_k", 32'(k), 32'(pick(8'h55, 8'hFF)));
        check("bb_55_busy", 32'(busy), 32'd1);
        check("bb_55_done_clr", 32'(done), 32'd0);
        repeat (3) tick();
        check("bb_55_done", 32'(done), 32'd1);
        check("bb_55_q", 32'(q_fb), 32'h55);
        tick();

        // Reset during SETTLE abandons the operation
        tgt_if.tgt_valid = 1'b1;
        tgt_if.tgt_data  = 8'h0F;
        tick();
        tgt_if.tgt_valid = 1'b0;
        check("mr_drive_j", 32'(j), 32'(pick(8'h50, 8'h5A)));
        check("mr_drive_k", 32'(k), 32'(pick(8'h0A, 8'h5A)));
        tick();
        check("mr_settle_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_rst_outs", 32'({j, k, busy, done, err}), 32'd0);
        check("mr_rst_ready", 32'(tgt_if.tgt_ready), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mr_rel_ready", 32'(tgt_if.tgt_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_pulse", 32'({done, err, busy}), 32'd0);
        end

        // Bank 0F -> FF -> 0F
        run_xfer("tFF", 8'hFF, pick(8'h00, 8'hF0), 8'hF0);
        run_xfer("tgl", 8'h0F, 8'hF0, pick(8'h00, 8'hF0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_drive_ctrl.md
JK_DRIVE_CTRL -- requirements
Module: jk_drive_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, number of JK flops in the driven bank.
REQ-002 Parameter: SETTLE_CYC, default 1, cycles (>=1) with J=K=0 between a DRIVE and its CHECK.
REQ-003 Parameter: MAX_RETRY, default 2, re-drives allowed after a failed CHECK.
REQ-004 clk  input  1  rising-edge clock, shared with the driven JK bank.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tgt_valid  input  1  target request.
REQ-007 tgt_ready  output  1  high only in IDLE.
REQ-008 tgt_data  input  WIDTH  desired bank state.
REQ-009 q_fb  input  WIDTH  Q outputs fed back from the bank.
REQ-010 j  output  WIDTH  registered J drive, one bit per flop.
REQ-011 k  output  WIDTH  registered K drive, one bit per flop.
REQ-012 busy  output  1  high in DRIVE, SETTLE and CHECK.
REQ-013 done  output  1  one-cycle pulse: bank matched target.
REQ-014 err  output  1  one-cycle pulse: retries exhausted without match.

Function
REQ-015 Bank JK convention SHALL be: {j,k}=00 hold, 10 clear to 0, 01 set to 1, 11 toggle; bank reset value all-ones.
REQ-016 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK.
REQ-017 Transfer occurs on the edge where tgt_valid && tgt_ready; tgt_data SHALL be latched into an internal target register and the FSM SHALL enter DRIVE.
REQ-018 On every entry to DRIVE, j/k SHALL be registered per bit from q_fb and target: equal -> 00; q=1,t=0 -> 10; q=0,t=1 -> 01.
REQ-019 j/k SHALL be non-zero for exactly the single DRIVE cycle and 0 in every other state.
REQ-020 SETTLE SHALL last SETTLE_CYC cycles, then the FSM SHALL enter CHECK.
REQ-021 CHECK (one cycle) SHALL compare q_fb to target: match -> IDLE with done=1 for the next cycle.
REQ-022 On mismatch with retry count < MAX_RETRY, the FSM SHALL increment the count and re-enter DRIVE, recomputing j/k from current q_fb.
REQ-023 On mismatch with retry count == MAX_RETRY, the FSM SHALL go to IDLE with err=1 for the next cycle.
REQ-024 Latency with a cooperative bank: done SHALL be high in the cycle starting 2+SETTLE_CYC edges after the transfer edge.
REQ-025 A target equal to q_fb SHALL still pass DRIVE (all 00), SETTLE and CHECK and end in done.
REQ-026 tgt_valid while busy SHALL be ignored (tgt_ready=0); the pending request transfers in the first IDLE cycle, including the done/err cycle.
REQ-027 done and err SHALL never be high in the same cycle.
REQ-028 Retry count SHALL clear on every transfer.

Reset
REQ-029 rst SHALL immediately force IDLE, j=0, k=0, busy=0, done=0, err=0, retry count 0, target 0.
REQ-030 tgt_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-031 rst mid-operation SHALL abandon the operation with no done or err pulse.

Configuration
REQ-032 Macro JK_DRIVE_TOGGLE_EN defined: every bit that must change SHALL be driven 11 (toggle); unchanged bits 00.
REQ-033 Macro undefined: directed set/clear encoding per REQ-018; code 11 is never emitted.

Structure
REQ-034 Package jk_pkg SHALL hold the FSM state enum and the excitation constants JK_HOLD, JK_CLR, JK_SET, JK_TGL.
REQ-035 Sub-module jk_excite (combinational, per-bank): q, target -> j, k. It SHALL implement REQ-018 and REQ-032/033.

Verification (WIDTH=8, SETTLE_CYC=1, MAX_RETRY=2, behavioural JK bank model, reset FF)
REQ-036 After reset, tgt_data=8'h0F -> DRIVE j=8'hF0 k=8'h00; done 3 edges after transfer; q_fb=8'h0F.
REQ-037 q_fb=8'h0F, tgt_data=8'h0F -> j=k=0 throughout; done after 3 edges; err=0.
REQ-038 Model bit0 stuck at 0, q=8'h00, tgt=8'h01 -> 3 DRIVE cycles with j=0,k=8'h01 each; err pulse once; no done.
REQ-039 tgt_valid held for targets 8'hAA then 8'h55 -> second transfer in the done cycle of the first; tgt_ready=0 while busy.
REQ-040 rst pulsed during SETTLE -> j,k,busy,done,err all 0 immediately; tgt_ready=1 the cycle after release; no pulse.
REQ-041 JK_DRIVE_TOGGLE_EN defined, q=8'hFF, tgt=8'h0F -> j=8'hF0, k=8'hF0; done after 3 edges.
